// File: rtl/johnson_pkg.sv
// Shared types and helpers for the Johnson phase tracker.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package johnson_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACQ  = 2'd1,
      ST_LOCK = 2'd2,
      ST_ERR  = 2'd3
   } jpt_state_e;

   // Functions take a wide vector plus the active width so any WIDTH up to 32 works.
   localparam int JC_MAX_W = 32;

   // Legal Johnson code: at most one transition between adjacent bits.
   function automatic logic jc_legal(input logic [JC_MAX_W-1:0] s, input int n);
      int trans;
      trans = 0;
      for (int i = 0; i < JC_MAX_W - 1; i++) begin
         if ((i < n - 1) && (s[i] != s[i+1])) trans++;
      end
      return (trans <= 1);
   endfunction

   // Phase index: the count of ones while filling from bit 0, mirrored while draining.
   function automatic int jc_decode(input logic [JC_MAX_W-1:0] s, input int n);
      int p;
      p = 0;
      for (int i = 0; i < JC_MAX_W; i++) begin
         if ((i < n) && s[i]) p++;
      end
      if (s[0] || (p == 0)) return p;
      return 2 * n - p;
   endfunction

   // Expected next phase, wrapping from 2N-1 back to 0.
   function automatic int jc_succ(input int phase, input int n);
      return (phase + 1) % (2 * n);
   endfunction

endpackage

// File: rtl/johnson_decode.sv
// Decodes a Johnson counter state into a legality flag and a binary phase index.
// Latency: purely combinational.
// Backpressure: none; the outputs follow the input continuously.
module johnson_decode
   import johnson_pkg::*;
#(
   parameter  int WIDTH = 4,
   localparam int PH_W  = $clog2(2 * WIDTH)
) (
   input  logic [WIDTH-1:0] i_jc_state,
   output logic             o_legal,
   output logic [PH_W-1:0]  o_phase
);

   logic [JC_MAX_W-1:0] s_ext;

   assign s_ext = JC_MAX_W'(i_jc_state);

   // Pure decode; the phase value is meaningless when the code is illegal.
   always_comb begin
      o_legal = jc_legal(s_ext, WIDTH);
      o_phase = PH_W'(jc_decode(s_ext, WIDTH));
   end

endmodule

// File: rtl/johnson_phase_tracker.sv
// Tracks Johnson counter phase, declares lock after LOCK_CNT successor steps, counts hits.
// Latency: one cycle; every output is registered from the sample at the previous edge.
// Backpressure: none; a sample is taken every cycle. Optional hit map: JPT_MATCH_MAP_EN.
module johnson_phase_tracker
   import johnson_pkg::*;
#(
   parameter  int WIDTH    = 4,
   parameter  int LOCK_CNT = 4,
   parameter  int CNT_W    = 8,
   localparam int PH_W     = $clog2(2 * WIDTH)
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [WIDTH-1:0]   i_jc_state,
   input  logic               i_match,
   input  logic               i_clr,
   output logic [PH_W-1:0]    o_phase,
   output logic               o_locked,
   output logic               o_step_err,
   output logic               o_code_err,
   output logic [CNT_W-1:0]   o_match_cnt,
   output logic [2*WIDTH-1:0] o_match_map
);

   localparam int STEP_W = $clog2(LOCK_CNT + 1);

   jpt_state_e        state_q, state_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic [PH_W-1:0]   phase_q, phase_d;
   logic              step_err_q, step_err_d;
   logic              code_err_q, code_err_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              dec_legal;
   logic [PH_W-1:0]   dec_phase;
   logic              is_hold;
   logic              is_succ;
   logic              match_hit;

   johnson_decode #(.WIDTH(WIDTH)) u_decode (
      .i_jc_state (i_jc_state),
      .o_legal    (dec_legal),
      .o_phase    (dec_phase)
   );

   assign is_hold   = (dec_phase == phase_q);
   assign is_succ   = (dec_phase == PH_W'(jc_succ(int'(phase_q), WIDTH)));
   // A hit counts only when the tracker was locked before this edge and no clear is pending.
   assign match_hit = (state_q == ST_LOCK) && i_match && !i_clr;

   // Next-state logic: clear wins over everything, ERR ignores the sample stream.
   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      phase_d    = phase_q;
      step_err_d = 1'b0;
      code_err_d = code_err_q;
      cnt_d      = cnt_q;
      if (i_clr) begin
         state_d    = ST_IDLE;
         step_d     = '0;
         code_err_d = 1'b0;
         cnt_d      = '0;
      end else begin
         if (match_hit && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
         if ((state_q != ST_ERR) && !dec_legal) begin
            code_err_d = 1'b1;
            state_d    = ST_ERR;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  phase_d = dec_phase;
                  step_d  = '0;
                  state_d = ST_ACQ;
               end
               ST_ACQ: begin
                  if (is_hold) begin
                     state_d = ST_ACQ;
                  end else if (is_succ) begin
                     phase_d = dec_phase;
                     step_d  = step_q + STEP_W'(1);
                     if (int'(step_q) + 1 >= LOCK_CNT) state_d = ST_LOCK;
                  end else begin
                     phase_d    = dec_phase;
                     step_d     = '0;
                     step_err_d = 1'b1;
                  end
               end
               ST_LOCK: begin
                  if (is_succ) begin
                     phase_d = dec_phase;
                  end else if (!is_hold) begin
                     phase_d    = dec_phase;
                     step_d     = '0;
                     step_err_d = 1'b1;
                     state_d    = ST_ACQ;
                  end
               end
               default: state_d = ST_ERR;
            endcase
         end
      end
   end

   // State and output registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         step_q     <= '0;
         phase_q    <= '0;
         step_err_q <= 1'b0;
         code_err_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         step_q     <= step_d;
         phase_q    <= phase_d;
         step_err_q <= step_err_d;
         code_err_q <= code_err_d;
         cnt_q      <= cnt_d;
      end
   end

`ifdef JPT_MATCH_MAP_EN
   logic [2*WIDTH-1:0] map_q, map_d;

   // Record which phases saw a counted hit; bits stay set until clear.
   always_comb begin
      map_d = map_q;
      if (i_clr) map_d = '0;
      else if (match_hit && dec_legal) map_d[dec_phase] = 1'b1;
   end

   // Hit map register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) map_q <= '0;
      else       map_q <= map_d;
   end

   assign o_match_map = map_q;
`else
   assign o_match_map = '0;
`endif

   assign o_phase     = phase_q;
   assign o_locked    = (state_q == ST_LOCK);
   assign o_step_err  = step_err_q;
   assign o_code_err  = code_err_q;
   assign o_match_cnt = cnt_q;

endmodule
